// File: rtl/ula_pkg.sv
// Shared types and constants for the ALU operation sequencer.
package ula_pkg;

    typedef enum logic [3:0] {
        ULA_ADD    = 4'd0,
        ULA_SUB    = 4'd1,
        ULA_MUL    = 4'd2,
        ULA_DIV    = 4'd3,
        ULA_AND    = 4'd4,
        ULA_OR     = 4'd5,
        ULA_NAND   = 4'd6,
        ULA_XOR    = 4'd7,
        ULA_NOR    = 4'd8,
        ULA_EQ     = 4'd9,
        ULA_GTE    = 4'd10,
        ULA_LTE    = 4'd11,
        ULA_RSVD12 = 4'd12,
        ULA_RSVD13 = 4'd13,
        ULA_RSVD14 = 4'd14,
        ULA_RSVD15 = 4'd15
    } ula_op_e;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_SETTLE = 2'd1,
        SEQ_RESP   = 2'd2
    } seq_state_e;

    localparam logic [3:0] ULA_OP_DIV        = 4'd3;
    localparam logic [3:0] ULA_OP_CMP_FIRST  = 4'd9;
    localparam logic [3:0] ULA_OP_RSVD_FIRST = 4'd12;

    // Counter preload for a given settle time; out-of-range values clamp to 1..15.
    function automatic logic [3:0] settle_load(input int cycles);
        int c;
        c = cycles;
        if (c < 1)  c = 1;
        if (c > 15) c = 15;
        return 4'(c - 1);
    endfunction

endpackage

// File: rtl/ula_settle_counter.sv
// 4-bit down-counter with synchronous load; done flags a zero count.
module ula_settle_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [3:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign done = (count == 4'd0);

endmodule

// File: rtl/ula_op_sequencer.sv
// Registered command/response front end for the combinational ula ALU.
// Optional accumulator and operand feedback enabled by defining ULA_SEQ_ACC_EN.
//
// state  | meaning
// IDLE   | cmd_ready high, waiting for a command
// SETTLE | operands held on the ALU while the settle counter runs down
// RESP   | captured response presented until rsp_ready
module ula_op_sequencer
    import ula_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    input  logic        cmd_use_acc,
    output logic [7:0]  ula_a,
    output logic [7:0]  ula_b,
    output logic [3:0]  ula_sel,
    input  logic [15:0] ula_result,
    input  logic        ula_zero,
    input  logic        ula_sign,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_zero,
    output logic        rsp_sign,
    output logic        rsp_err,
    output logic [15:0] acc_out
);

    localparam logic [1:0] ST_IDLE   = SEQ_IDLE;
    localparam logic [1:0] ST_SETTLE = SEQ_SETTLE;
    localparam logic [1:0] ST_RESP   = SEQ_RESP;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        cmd_fire;
    logic        rsp_fire;
    logic        cnt_done;
    logic        capture;
    logic [7:0]  eff_a;

    logic        last_zero;
    logic        last_sign;

    logic        is_rsvd;
    logic        is_cmp;
    logic        is_div0;
    logic        cap_err;
    logic        cap_update;
    logic [15:0] cap_result;
    logic        cap_zero;
    logic        cap_sign;

    assign cmd_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign capture   = (state == ST_SETTLE) && cnt_done;

    ula_settle_counter u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cmd_fire),
        .load_val (settle_load(SETTLE_CYCLES)),
        .dec      (state == ST_SETTLE),
        .done     (cnt_done)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (cmd_fire) state_nxt = ST_SETTLE;
            ST_SETTLE: if (cnt_done) state_nxt = ST_RESP;
            ST_RESP:   if (rsp_fire) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef ULA_SEQ_ACC_EN
    logic [15:0] acc_q;

    assign eff_a   = cmd_use_acc ? acc_q[7:0] : cmd_a;
    assign acc_out = acc_q;

    // Full 16-bit result kept; only the low byte is ever fed back as operand a.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 16'h0000;
        end else if (capture && cap_update) begin
            acc_q <= ula_result;
        end
    end
`else
    logic unused_use_acc;

    assign unused_use_acc = cmd_use_acc;
    assign eff_a          = cmd_a;
    assign acc_out        = 16'h0000;
`endif

    // Operands stay put from one fire to the next so the ALU output is stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ula_a   <= 8'h00;
            ula_b   <= 8'h00;
            ula_sel <= 4'h0;
        end else if (cmd_fire) begin
            ula_a   <= eff_a;
            ula_b   <= cmd_b;
            ula_sel <= cmd_op;
        end
    end

    always_comb begin
        is_rsvd    = (ula_sel >= ULA_OP_RSVD_FIRST);
        is_cmp     = (ula_sel >= ULA_OP_CMP_FIRST) && !is_rsvd;
        is_div0    = (ula_sel == ULA_OP_DIV) && (ula_b == 8'h00);
        cap_err    = is_rsvd || is_div0;
        cap_update = !cap_err && !is_cmp;
        cap_result = ula_result;
        cap_zero   = ula_zero;
        cap_sign   = ula_sign;
        if (cap_err) begin
            cap_result = 16'h0000;
            cap_zero   = 1'b0;
            cap_sign   = 1'b0;
        end else if (is_cmp) begin
            cap_zero   = last_zero;
            cap_sign   = last_sign;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= 16'h0000;
            rsp_zero   <= 1'b0;
            rsp_sign   <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (capture) begin
            rsp_result <= cap_result;
            rsp_zero   <= cap_zero;
            rsp_sign   <= cap_sign;
            rsp_err    <= cap_err;
        end
    end

    // Compare ops report the flags of the last arithmetic/logic op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_zero <= 1'b0;
            last_sign <= 1'b0;
        end else if (capture && cap_update) begin
            last_zero <= ula_zero;
            last_sign <= ula_sign;
        end
    end

endmodule

// File: tb/tb_ula_op_sequencer.sv
// Scoreboard bench for ula_op_sequencer with a behavioural ALU model.
module tb_ula_op_sequencer;

    localparam int SETTLE = 3;

`ifdef ULA_SEQ_ACC_EN
    localparam bit ACC = 1'b1;
`else
    localparam bit ACC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [3:0]  cmd_op = 4'h0;
    logic [7:0]  cmd_a = 8'h00;
    logic [7:0]  cmd_b = 8'h00;
    logic        cmd_use_acc = 1'b0;
    logic [7:0]  ula_a;
    logic [7:0]  ula_b;
    logic [3:0]  ula_sel;
    logic [15:0] ula_result;
    logic        ula_zero;
    logic        ula_sign;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic        rsp_zero;
    logic        rsp_sign;
    logic        rsp_err;
    logic [15:0] acc_out;

    typedef struct {
        logic [15:0] res;
        logic        z;
        logic        s;
        logic        e;
        logic [15:0] acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ula_op_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .ula_a       (ula_a),
        .ula_b       (ula_b),
        .ula_sel     (ula_sel),
        .ula_result  (ula_result),
        .ula_zero    (ula_zero),
        .ula_sign    (ula_sign),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_sign    (rsp_sign),
        .rsp_err     (rsp_err),
        .acc_out     (acc_out)
    );

    logic [15:0] alu_r;
    always_comb begin
        alu_r = 16'h0000;
        case (ula_sel)
            4'd0:  alu_r = {8'h00, ula_a} + {8'h00, ula_b};
            4'd1:  alu_r = {8'h00, ula_a} - {8'h00, ula_b};
            4'd2:  alu_r = {8'h00, ula_a} * {8'h00, ula_b};
            4'd3:  alu_r = (ula_b != 8'h00) ? {8'h00, ula_a / ula_b} : 16'hFFFF;
            4'd4:  alu_r = {8'h00, ula_a & ula_b};
            4'd5:  alu_r = {8'h00, ula_a | ula_b};
            4'd6:  alu_r = {8'h00, ~(ula_a & ula_b)};
            4'd7:  alu_r = {8'h00, ula_a ^ ula_b};
            4'd8:  alu_r = {8'h00, ~(ula_a | ula_b)};
            4'd9:  alu_r = {15'h0000, ula_a == ula_b};
            4'd10: alu_r = {15'h0000, ula_a >= ula_b};
            4'd11: alu_r = {15'h0000, ula_a <= ula_b};
            default: alu_r = 16'hDEAD;
        endcase
    end
    assign ula_result = alu_r;
    assign ula_zero   = (alu_r == 16'h0000);
    assign ula_sign   = alu_r[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] r, input logic z, input logic s,
                                input logic e, input logic [15:0] acc_val);
        exp_t x;
        x.res = r;
        x.z   = z;
        x.s   = s;
        x.e   = e;
        x.acc = ACC ? acc_val : 16'h0000;
        return x;
    endfunction

    // Monitor: one pop per response handshake.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underflow: response 0x%0h with no expected entry", rsp_result);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_result", rsp_result, mon_e.res);
                chk("rsp_zero", rsp_zero, mon_e.z);
                chk("rsp_sign", rsp_sign, mon_e.s);
                chk("rsp_err", rsp_err, mon_e.e);
                chk("acc_out", acc_out, mon_e.acc);
            end
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
    endtask

    task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic use_acc, input logic [7:0] exp_ua,
                           input exp_t e, input int hold);
        int t;
        wait_ready();
        rsp_ready = (hold == 0);
        sb.push_back(e);
        cmd_op = op;
        cmd_a = a;
        cmd_b = b;
        cmd_use_acc = use_acc;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("ula_a", ula_a, exp_ua);
        chk("ula_b", ula_b, b);
        chk("ula_sel", ula_sel, op);
        chk("cmd_ready_busy", cmd_ready, 0);
        for (int k = 1; k < SETTLE; k++) begin
            @(posedge clk);
            #1;
            chk("rsp_valid_early", rsp_valid, 0);
        end
        @(posedge clk);
        #1;
        chk("rsp_valid_latency", rsp_valid, 1);
        if (hold > 0) begin
            cmd_valid = 1'b1;
            cmd_op = 4'h0;
            cmd_a = 8'hAA;
            cmd_b = 8'h55;
            for (int k = 0; k < hold; k++) begin
                @(posedge clk);
                #1;
                chk("hold_valid", rsp_valid, 1);
                chk("hold_result", rsp_result, e.res);
                chk("hold_cmd_ready", cmd_ready, 0);
                chk("hold_ula_a", ula_a, exp_ua);
            end
            cmd_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        t = 0;
        while (rsp_valid && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("rsp_released", rsp_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        #12;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_ula_a", ula_a, 0);
        chk("rst_result", rsp_result, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_cmd(4'd0, 8'h10, 8'h05, 1'b0, 8'h10, mk(16'h0015, 0, 0, 0, 16'h0015), 0);
        run_cmd(4'd2, 8'h44, 8'h03, 1'b1, ACC ? 8'h15 : 8'h44,
                mk(ACC ? 16'h003F : 16'h00CC, 0, 0, 0, 16'h003F), 0);
        run_cmd(4'd3, 8'h20, 8'h00, 1'b0, 8'h20, mk(16'h0000, 0, 0, 1, 16'h003F), 0);
        run_cmd(4'd13, 8'h01, 8'h02, 1'b0, 8'h01, mk(16'h0000, 0, 0, 1, 16'h003F), 0);
        run_cmd(4'd1, 8'h07, 8'h07, 1'b0, 8'h07, mk(16'h0000, 1, 0, 0, 16'h0000), 0);
        run_cmd(4'd9, 8'h05, 8'h05, 1'b0, 8'h05, mk(16'h0001, 1, 0, 0, 16'h0000), 0);
        run_cmd(4'd1, 8'h05, 8'h07, 1'b0, 8'h05, mk(16'hFFFE, 0, 1, 0, 16'hFFFE), 0);
        run_cmd(4'd10, 8'h09, 8'h02, 1'b0, 8'h09, mk(16'h0001, 0, 1, 0, 16'hFFFE), 0);
        run_cmd(4'd11, 8'h00, 8'hFE, 1'b1, ACC ? 8'hFE : 8'h00, mk(16'h0001, 0, 1, 0, 16'hFFFE), 0);
        run_cmd(4'd4, 8'hF0, 8'h3C, 1'b0, 8'hF0, mk(16'h0030, 0, 0, 0, 16'h0030), 0);
        run_cmd(4'd3, 8'h64, 8'h07, 1'b0, 8'h64, mk(16'h000E, 0, 0, 0, 16'h000E), 0);
        run_cmd(4'd6, 8'hFF, 8'hFF, 1'b0, 8'hFF, mk(16'h0000, 1, 0, 0, 16'h0000), 0);
        run_cmd(4'd9, 8'h02, 8'h02, 1'b0, 8'h02, mk(16'h0001, 1, 0, 0, 16'h0000), 5);
        run_cmd(4'd1, 8'h05, 8'h07, 1'b0, 8'h05, mk(16'hFFFE, 0, 1, 0, 16'hFFFE), 0);

        // Reset while a response is waiting for the consumer.
        wait_ready();
        rsp_ready = 1'b0;
        cmd_op = 4'd0;
        cmd_a = 8'h01;
        cmd_b = 8'h01;
        cmd_use_acc = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (SETTLE) @(posedge clk);
        #1;
        chk("pre_rst_valid", rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_cmd_ready", cmd_ready, 1);
        chk("midrst_result", rsp_result, 0);
        chk("midrst_ula_sel", ula_sel, 0);
        chk("midrst_acc", acc_out, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_cmd(4'd9, 8'h01, 8'h01, 1'b0, 8'h01, mk(16'h0001, 0, 0, 0, 16'h0000), 0);
        run_cmd(4'd7, 8'h55, 8'h0F, 1'b0, 8'h55, mk(16'h005A, 0, 0, 0, 16'h005A), 0);
        run_cmd(4'd0, 8'h00, 8'h01, 1'b1, ACC ? 8'h5A : 8'h00,
                mk(ACC ? 16'h005B : 16'h0001, 0, 0, 0, 16'h005B), 0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
